// File: rtl/ysyx_23060332_wbu_pkg.sv
// Shared constants and types for the write-back unit.
package ysyx_23060332_wbu_pkg;

   localparam int unsigned WB_DEPTH = 2;
   localparam int unsigned WB_XLEN  = 32;
   localparam int unsigned REG_AW   = 5;

   // Load size/sign encodings carried on in_funct3.
   typedef enum logic [2:0] {
      FN_LB  = 3'b000,
      FN_LH  = 3'b001,
      FN_LW  = 3'b010,
      FN_LBU = 3'b100,
      FN_LHU = 3'b101
   } load_fn_e;

   function automatic logic rd_writes(input logic wen, input logic [REG_AW-1:0] rd);
      return wen && (rd != '0);
   endfunction

endpackage

// File: rtl/ysyx_23060332_wbu_if.sv
// EXU/LSU result channel into the write-back unit.
interface ysyx_23060332_wbu_if
   import ysyx_23060332_wbu_pkg::*;
#(
   parameter int unsigned XLEN = WB_XLEN
);
   logic              in_valid;
   logic              in_ready;
   logic [REG_AW-1:0] in_rd;
   logic              in_rd_wen;
   logic              in_is_load;
   logic [2:0]        in_funct3;
   logic [1:0]        in_addr_lo;
   logic [XLEN-1:0]   in_data;

   modport master (
      output in_valid, in_rd, in_rd_wen, in_is_load, in_funct3, in_addr_lo, in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_rd, in_rd_wen, in_is_load, in_funct3, in_addr_lo, in_data,
      output in_ready
   );
endinterface

// File: rtl/ysyx_23060332_wbu_fifo.sv
// Generic DEPTH x W valid/ready FIFO; full/empty decided from the registered count.
module ysyx_23060332_wbu_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push_valid,
   output logic         o_push_ready,
   input  logic [W-1:0] i_push_data,
   output logic         o_pop_valid,
   input  logic         i_pop_ready,
   output logic [W-1:0] o_pop_data
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign o_push_ready = (r_count != CW'(DEPTH));
   assign o_pop_valid  = (r_count != '0);
   assign o_pop_data   = r_mem[r_rptr];
   assign w_push       = i_push_valid && o_push_ready;
   assign w_pop        = o_pop_valid && i_pop_ready;

   // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_push_data;
            r_wptr        <= r_wptr + AW'(1);
         end
         if (w_pop) r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/ysyx_23060332_wbu.sv
// Write-back unit: formats load data, buffers results, retires one per cycle
// into the register file and tracks pending destination registers.
module ysyx_23060332_wbu
   import ysyx_23060332_wbu_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH,
   parameter int unsigned XLEN  = WB_XLEN,
   parameter int unsigned NREG  = 32
) (
   input  logic              clk,
   input  logic              rst,
   ysyx_23060332_wbu_if.slave exu,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic [REG_AW-1:0] rs1_q,
   input  logic [REG_AW-1:0] rs2_q,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic              rd_busy,
   output logic [REG_AW-1:0] waddr,
   output logic [XLEN-1:0]   wdata,
   output logic              reg_wen,
   output logic [31:0]       retire_cnt
);
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic              rd_wen;
      logic [XLEN-1:0]   data;
   } entry_t;

   localparam int unsigned EW = $bits(entry_t);

   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [XLEN-1:0] w_fmt;
   entry_t          w_enq;
   entry_t          w_head;
   logic [EW-1:0]   w_head_raw;
   logic            w_head_valid;
   logic            w_clr;
   logic            w_set;
   logic            w_waw;
   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busy_nxt;
   logic [31:0]     r_retire_cnt;

   // Load formatting happens before enqueue so each entry holds its final value.
   always_comb begin
      w_byte = exu.in_data[{exu.in_addr_lo, 3'b000} +: 8];
      w_half = exu.in_data[{exu.in_addr_lo[1], 4'b0000} +: 16];
      w_fmt  = exu.in_data;
      if (exu.in_is_load) begin
         case (exu.in_funct3)
            FN_LB:   w_fmt = {{(XLEN-8){w_byte[7]}}, w_byte};
            FN_LBU:  w_fmt = {{(XLEN-8){1'b0}}, w_byte};
            FN_LH:   w_fmt = {{(XLEN-16){w_half[15]}}, w_half};
            FN_LHU:  w_fmt = {{(XLEN-16){1'b0}}, w_half};
            default: w_fmt = exu.in_data;
         endcase
      end
   end

   assign w_enq.rd     = exu.in_rd;
   assign w_enq.rd_wen = exu.in_rd_wen;
   assign w_enq.data   = w_fmt;

   ysyx_23060332_wbu_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .i_push_valid (exu.in_valid),
      .o_push_ready (exu.in_ready),
      .i_push_data  (w_enq),
      .o_pop_valid  (w_head_valid),
      .i_pop_ready  (1'b1),
      .o_pop_data   (w_head_raw)
   );

   assign w_head = w_head_raw;

   // Head retires unconditionally every cycle it is valid.
   assign w_clr   = w_head_valid && rd_writes(w_head.rd_wen, w_head.rd);
   assign w_set   = iss_valid && (iss_rd != '0);
   assign reg_wen = w_clr;
   assign waddr   = w_head_valid ? w_head.rd : '0;
   assign wdata   = w_head_valid ? w_head.data : '0;

   // Scoreboard next state: clear first so a same-cycle set of the same rd wins.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_clr) w_busy_nxt[w_head.rd] = 1'b0;
      if (w_set) w_busy_nxt[iss_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_busy <= '0;
      else     r_busy <= w_busy_nxt;
   end

   // Count of dequeued results, wrapping naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               r_retire_cnt <= '0;
      else if (w_head_valid) r_retire_cnt <= r_retire_cnt + 32'd1;
   end

   assign retire_cnt = r_retire_cnt;
   assign rs1_busy   = r_busy[rs1_q];
   assign rs2_busy   = r_busy[rs2_q];
   assign rd_busy    = r_busy[iss_rd];

   // Re-claiming a busy rd is only safe when its pending write retires this same edge.
   assign w_waw = w_set && rd_busy && !(w_clr && (w_head.rd == iss_rd));

   a_no_waw_issue: assert property (@(posedge clk) disable iff (rst) !w_waw);
endmodule

// File: tb/tb_ysyx_23060332_wbu.sv
// Directed bench for the write-back unit with a result scoreboard queue.
module tb_ysyx_23060332_wbu;
   typedef struct {
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic [4:0]  rs1_q;
   logic [4:0]  rs2_q;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        rd_busy;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        reg_wen;
   logic [31:0] retire_cnt;

   int          checks;
   int          errors;
   exp_t        q[$];
   exp_t        m_e;
   int unsigned exp_cnt;

   ysyx_23060332_wbu_if #(.XLEN(32)) bus ();

   ysyx_23060332_wbu #(
      .DEPTH (2),
      .XLEN  (32),
      .NREG  (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .exu        (bus),
      .iss_valid  (iss_valid),
      .iss_rd     (iss_rd),
      .rs1_q      (rs1_q),
      .rs2_q      (rs2_q),
      .rs1_busy   (rs1_busy),
      .rs2_busy   (rs2_busy),
      .rd_busy    (rd_busy),
      .waddr      (waddr),
      .wdata      (wdata),
      .reg_wen    (reg_wen),
      .retire_cnt (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_fmt(input logic is_load, input logic [2:0] f3,
                                             input logic [1:0] lo, input logic [31:0] d);
      logic [31:0] b;
      logic [31:0] h;
      b = (d >> (lo * 8)) & 32'hFF;
      h = (d >> (lo[1] ? 16 : 0)) & 32'hFFFF;
      if (!is_load) return d;
      case (f3)
         3'b000:  return b[7]  ? (b | 32'hFFFFFF00) : b;
         3'b100:  return b;
         3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
         3'b101:  return h;
         default: return d;
      endcase
   endfunction

   // Record every accepted result with its expected final value.
   always @(posedge clk) begin
      if (!rst && bus.in_valid && bus.in_ready)
         q.push_back('{rd: bus.in_rd, wen: bus.in_rd_wen,
                       data: model_fmt(bus.in_is_load, bus.in_funct3, bus.in_addr_lo, bus.in_data)});
   end

   // Compare the write port against the oldest outstanding result each cycle.
   always @(negedge clk) begin
      if (!rst) begin
         chk("retire_cnt", 64'(retire_cnt), 64'(exp_cnt));
         if (q.size() != 0) begin
            m_e = q.pop_front();
            chk("reg_wen", 64'(reg_wen), 64'(m_e.wen && (m_e.rd != 5'd0)));
            chk("waddr", 64'(waddr), 64'(m_e.rd));
            chk("wdata", 64'(wdata), 64'(m_e.data));
            exp_cnt++;
         end else begin
            chk("idle_wen", 64'(reg_wen), 64'(0));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [4:0] rd, input logic wen, input logic ld,
                       input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] d);
      logic        ok;
      int unsigned n;
      bus.in_valid   = 1'b1;
      bus.in_rd      = rd;
      bus.in_rd_wen  = wen;
      bus.in_is_load = ld;
      bus.in_funct3  = f3;
      bus.in_addr_lo = lo;
      bus.in_data    = d;
      n = 0;
      do begin
         ok = bus.in_ready;
         tick();
         n++;
      end while (!ok && n < 50);
      chk("accept", 64'(ok), 64'(1));
   endtask

   initial begin
      checks = 0; errors = 0; exp_cnt = 0;
      rst = 1'b1;
      iss_valid = 1'b0; iss_rd = '0; rs1_q = '0; rs2_q = '0;
      bus.in_valid = 1'b0; bus.in_rd = '0; bus.in_rd_wen = 1'b0; bus.in_is_load = 1'b0;
      bus.in_funct3 = '0; bus.in_addr_lo = '0; bus.in_data = '0;
      tick();
      tick();
      chk("rst_wen", 64'(reg_wen), 64'(0));
      chk("rst_waddr", 64'(waddr), 64'(0));
      chk("rst_wdata", 64'(wdata), 64'(0));
      chk("rst_cnt", 64'(retire_cnt), 64'(0));
      chk("rst_ready", 64'(bus.in_ready), 64'(1));
      rst = 1'b0;
      tick();

      // Single ALU result, visible the cycle after acceptance.
      send(5'd5, 1'b1, 1'b0, 3'b000, 2'd0, 32'hDEADBEEF);
      chk("alu_wen", 64'(reg_wen), 64'(1));
      chk("alu_waddr", 64'(waddr), 64'(5));
      chk("alu_wdata", 64'(wdata), 64'hDEADBEEF);
      bus.in_valid = 1'b0;
      tick();
      chk("alu_cnt", 64'(retire_cnt), 64'(1));

      // Load formatting.
      send(5'd10, 1'b1, 1'b1, 3'b000, 2'd1, 32'h8081F2F3);
      chk("lb", 64'(wdata), 64'hFFFFFFF2);
      send(5'd11, 1'b1, 1'b1, 3'b100, 2'd3, 32'h8081F2F3);
      chk("lbu", 64'(wdata), 64'h00000080);
      send(5'd12, 1'b1, 1'b1, 3'b001, 2'd2, 32'h8081F2F3);
      chk("lh", 64'(wdata), 64'hFFFF8081);
      send(5'd13, 1'b1, 1'b1, 3'b101, 2'd0, 32'h8081F2F3);
      chk("lhu", 64'(wdata), 64'h0000F2F3);
      send(5'd14, 1'b1, 1'b1, 3'b010, 2'd3, 32'h8081F2F3);
      send(5'd15, 1'b1, 1'b1, 3'b001, 2'd1, 32'h12348765);

      // x0 and non-writing results retire without a write.
      send(5'd0, 1'b1, 1'b0, 3'b000, 2'd0, 32'h11111111);
      chk("x0_wen", 64'(reg_wen), 64'(0));
      send(5'd6, 1'b0, 1'b0, 3'b000, 2'd0, 32'h22222222);
      chk("nowen_wen", 64'(reg_wen), 64'(0));
      bus.in_valid = 1'b0;
      iss_valid = 1'b1; iss_rd = 5'd0; rs2_q = 5'd0;
      tick();
      iss_valid = 1'b0;
      chk("x0_rd_busy", 64'(rd_busy), 64'(0));
      chk("x0_rs2_busy", 64'(rs2_busy), 64'(0));

      // Scoreboard set, same-cycle set/clear, then clear.
      iss_valid = 1'b1; iss_rd = 5'd7; rs1_q = 5'd7;
      tick();
      iss_valid = 1'b0;
      chk("sb_rs1_set", 64'(rs1_busy), 64'(1));
      chk("sb_rd_set", 64'(rd_busy), 64'(1));
      send(5'd7, 1'b1, 1'b0, 3'b000, 2'd0, 32'h00000777);
      bus.in_valid = 1'b0;
      iss_valid = 1'b1; iss_rd = 5'd7;
      tick();
      iss_valid = 1'b0;
      chk("sb_set_wins", 64'(rs1_busy), 64'(1));
      send(5'd7, 1'b1, 1'b0, 3'b000, 2'd0, 32'h00000778);
      chk("sb_pending", 64'(rs1_busy), 64'(1));
      bus.in_valid = 1'b0;
      tick();
      chk("sb_clear", 64'(rs1_busy), 64'(0));

      // Back-to-back stream; the scoreboard queue checks order and completeness.
      for (int i = 0; i < 10; i++)
         send(5'(i + 1), 1'b1, 1'b0, 3'b000, 2'd0, $urandom());
      bus.in_valid = 1'b0;
      tick();

      // Reset in the middle of a stream with a register claimed.
      iss_valid = 1'b1; iss_rd = 5'd9; rs1_q = 5'd9;
      tick();
      iss_valid = 1'b0;
      chk("mid_busy_pre", 64'(rs1_busy), 64'(1));
      send(5'd9, 1'b1, 1'b0, 3'b000, 2'd0, 32'h99999999);
      send(5'd3, 1'b1, 1'b0, 3'b000, 2'd0, 32'h33333333);
      send(5'd4, 1'b1, 1'b0, 3'b000, 2'd0, 32'h44444444);
      rst = 1'b1;
      q.delete();
      exp_cnt = 0;
      #1;
      chk("mid_wen", 64'(reg_wen), 64'(0));
      chk("mid_ready", 64'(bus.in_ready), 64'(1));
      chk("mid_cnt", 64'(retire_cnt), 64'(0));
      for (int r = 0; r < 32; r++) begin
         rs1_q = 5'(r);
         #1;
         chk("mid_busy", 64'(rs1_busy), 64'(0));
      end
      bus.in_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      send(5'd20, 1'b1, 1'b0, 3'b000, 2'd0, 32'hCAFEF00D);
      bus.in_valid = 1'b0;

      for (int i = 0; i < 20 && q.size() != 0; i++) tick();
      tick();
      chk("drain", 64'(q.size()), 64'(0));
      chk("final_cnt", 64'(retire_cnt), 64'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
